two_digit_seg_monitor: RTL and testbench

Receive-side monitor for the two-digit seven-segment counter display.
- Samples the two 7-bit segment buses driven by a counter board and filters glitches.
- Decodes each stable pattern back to a value 0..99 and classifies each change as up-step, down-step (including 99<->0 wrap), illegal step or illegal segment code.
- Used on the test board for self-checking of the counter and for display loopback.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_to_bcd.sv | 29 ++
 rtl/two_digit_seg_monitor.sv | 116 +++++++++++
 tb/tb_two_digit_seg_monitor.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the two-digit seven-segment receive monitor.
// Segment codes use bit0=a .. bit6=g, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_CODE_0 = 7'h3F;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5B;
  localparam logic [6:0] SEG_CODE_3 = 7'h4F;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6D;
  localparam logic [6:0] SEG_CODE_6 = 7'h7D;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h6F;

  localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;
  localparam logic [6:0] MAX_VALUE     = 7'd99;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational seven-segment to BCD decoder; any code outside the ten
// digit patterns (including all-off) is flagged illegal.
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       illegal,
  output logic [3:0] digit
);

  always_comb begin
    illegal = 1'b0;
    digit   = DIGIT_ILLEGAL;
    case (seg)
      SEG_CODE_0: digit = 4'd0;
      SEG_CODE_1: digit = 4'd1;
      SEG_CODE_2: digit = 4'd2;
      SEG_CODE_3: digit = 4'd3;
      SEG_CODE_4: digit = 4'd4;
      SEG_CODE_5: digit = 4'd5;
      SEG_CODE_6: digit = 4'd6;
      SEG_CODE_7: digit = 4'd7;
      SEG_CODE_8: digit = 4'd8;
      SEG_CODE_9: digit = 4'd9;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/two_digit_seg_monitor.sv
// Receive-side monitor for a two-digit counter display: synchronizes and
// glitch-filters the segment buses, decodes them and classifies each change.
//
// state | meaning
// IDLE  | no legal value accepted since reset
// TRACK | a legal value is held; each new legal value is classified as a step
module two_digit_seg_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_one_in,
  input  logic [6:0]       seg_ten_in,
  output logic [6:0]       value,
  output logic             value_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             step_err,
  output logic             code_err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  state_t      state_q, state_d;
  logic [13:0] sync_1, syn, cand, acc;
  logic [7:0]  stab_cnt;
  logic        accept;
  logic        ten_ill, one_ill;
  logic [3:0]  ten_dig, one_dig;
  logic [6:0]  new_value, prev_inc, prev_dec;
  logic        vv_d, up_d, dn_d, serr_d, cerr_d, err_inc;

  seg_to_bcd u_ten (.seg(cand[13:7]), .illegal(ten_ill), .digit(ten_dig));
  seg_to_bcd u_one (.seg(cand[6:0]),  .illegal(one_ill), .digit(one_dig));

  // Accept fires on the sample that brings the run length up to STABLE_CYCLES.
  assign accept    = (syn == cand) && (stab_cnt == 8'(STABLE_CYCLES - 1)) && (cand != acc);
  assign new_value = 7'(ten_dig) * 7'd10 + 7'(one_dig);
  assign prev_inc  = (value == MAX_VALUE) ? 7'd0 : value + 7'd1;
  assign prev_dec  = (value == 7'd0) ? MAX_VALUE : value - 7'd1;
  assign locked    = (state_q == TRACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1   <= '0;
      syn      <= '0;
      cand     <= '0;
      acc      <= '0;
      stab_cnt <= '0;
    end else begin
      sync_1 <= {seg_ten_in, seg_one_in};
      syn    <= sync_1;
      if (syn != cand) begin
        cand     <= syn;
        stab_cnt <= 8'd1;
      end else if (stab_cnt != 8'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
      if (accept) acc <= cand;
    end
  end

  always_comb begin
    state_d = state_q;
    vv_d    = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    serr_d  = 1'b0;
    cerr_d  = 1'b0;
    err_inc = 1'b0;
    if (accept) begin
      if (ten_ill || one_ill) begin
        cerr_d  = 1'b1;
        err_inc = 1'b1;
      end else begin
        vv_d = 1'b1;
        if (state_q == IDLE) begin
          state_d = TRACK;
        end else if (new_value == prev_inc) begin
          up_d = 1'b1;
        end else if (new_value == prev_dec) begin
          dn_d = 1'b1;
        end else begin
          serr_d  = 1'b1;
          err_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      value       <= '0;
      value_valid <= 1'b0;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      step_err    <= 1'b0;
      code_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      value_valid <= vv_d;
      step_up     <= up_d;
      step_down   <= dn_d;
      step_err    <= serr_d;
      code_err    <= cerr_d;
      if (vv_d) value <= new_value;
      if (err_inc && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_two_digit_seg_monitor.sv
// Self-checking bench: scenario tasks plus randomized stimulus, all compared
// cycle by cycle against a run-length based reference model of the monitor.
module tb_two_digit_seg_monitor;

  localparam int S = 4;
  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct packed {
    logic [6:0] t;
    logic [6:0] o;
    logic [7:0] n;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_one_in = '0;
  logic [6:0] seg_ten_in = '0;
  logic [6:0] value;
  logic       value_valid, step_up, step_down, step_err, code_err, locked;
  logic [7:0] err_count;

  two_digit_seg_monitor #(.STABLE_CYCLES(S), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .seg_one_in(seg_one_in), .seg_ten_in(seg_ten_in),
    .value(value), .value_valid(value_valid), .step_up(step_up),
    .step_down(step_down), .step_err(step_err), .code_err(code_err),
    .err_count(err_count), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [13:0] hist[$];
  logic [13:0] m_acc;
  int          m_value, m_err;
  bit          m_locked, m_vv, m_up, m_dn, m_se, m_ce;

  // Events observed since the last clear
  int         ev_val[$];
  logic [2:0] ev_fl[$];
  int         n_ce;

  function automatic int dec(logic [6:0] c);
    for (int i = 0; i < 10; i++) if (c == CODES[i]) return i;
    return -1;
  endfunction

  function automatic logic [20:0] obs_vec();
    return {value, value_valid, step_up, step_down, step_err, code_err, err_count, locked};
  endfunction

  function automatic logic [20:0] exp_vec();
    return {7'(m_value), m_vv, m_up, m_dn, m_se, m_ce, 8'(m_err), m_locked};
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 8; i++) hist.push_back('0);
    m_acc = '0; m_value = 0; m_err = 0; m_locked = 0;
    m_vv = 0; m_up = 0; m_dn = 0; m_se = 0; m_ce = 0;
  endtask

  // A pattern is accepted when the synchronized stream (input two edges
  // late) has shown it for exactly S consecutive samples and it differs
  // from the last accepted pattern.
  task automatic model_edge(input logic [13:0] p);
    int n, t, o, v;
    logic [13:0] s;
    bit same;
    hist.push_back(p);
    if (hist.size() > 40) void'(hist.pop_front());
    m_vv = 0; m_up = 0; m_dn = 0; m_se = 0; m_ce = 0;
    n = hist.size();
    s = hist[n-3];
    same = 1;
    for (int i = 1; i < S; i++) if (hist[n-3-i] != s) same = 0;
    if (same && hist[n-3-S] != s && s != m_acc) begin
      m_acc = s;
      t = dec(s[13:7]);
      o = dec(s[6:0]);
      if (t < 0 || o < 0) begin
        m_ce = 1;
        if (m_err < 255) m_err++;
      end else begin
        v = t * 10 + o;
        if (m_locked) begin
          if (v == (m_value + 1) % 100) m_up = 1;
          else if (v == (m_value + 99) % 100) m_dn = 1;
          else begin
            m_se = 1;
            if (m_err < 255) m_err++;
          end
        end
        m_locked = 1;
        m_value  = v;
        m_vv     = 1;
      end
    end
  endtask

  task automatic clear_events();
    ev_val.delete(); ev_fl.delete(); n_ce = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic tick(input logic [6:0] t, input logic [6:0] o);
    seg_ten_in = t;
    seg_one_in = o;
    @(posedge clk);
    model_edge({t, o});
    #1;
    if (value_valid) begin
      ev_val.push_back(int'(value));
      ev_fl.push_back({step_up, step_down, step_err});
    end
    if (code_err) n_ce++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    seg_ten_in = 7'($urandom_range(0, 127));
    seg_one_in = 7'($urandom_range(0, 127));
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs_vec() !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), 21'h0);
    end
    rst = 1'b0;
    seg_ten_in = '0;
    seg_one_in = '0;
  endtask

  task automatic test_first_value();
    stim_t tbl[$] = '{'{7'h3F, 7'h5B, 8'd10}};
    clear_events();
    foreach (tbl[j]) for (int c = 0; c < int'(tbl[j].n); c++) begin
      tick(tbl[j].t, tbl[j].o);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL first_value cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (ev_val.size() != 1 || ev_val[0] != 2 || ev_fl[0] != 3'b000 || locked !== 1'b1 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL first_value_events: got n=%0d v=%0d fl=%b lk=%b err=%0d want n=1 v=2 fl=000 lk=1 err=0",
               ev_val.size(), ev_val.size() ? ev_val[0] : -1, ev_fl.size() ? ev_fl[0] : 3'b111, locked, err_count);
    end
  endtask

  task automatic test_up_down();
    stim_t tbl[$] = '{'{7'h3F, 7'h4F, 8'd10}, '{7'h3F, 7'h5B, 8'd10}};
    clear_events();
    foreach (tbl[j]) for (int c = 0; c < int'(tbl[j].n); c++) begin
      tick(tbl[j].t, tbl[j].o);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL up_down step %0d cyc %0d: got %h want %h", j, c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (ev_val.size() != 2 || ev_val[0] != 3 || ev_fl[0] != 3'b100 || ev_val[1] != 2 || ev_fl[1] != 3'b010) begin
      n_fail++;
      $display("FAIL up_down_events: got n=%0d want 3/up then 2/down", ev_val.size());
    end
  endtask

  task automatic test_wrap();
    stim_t tbl[$] = '{'{7'h6F, 7'h6F, 8'd10}, '{7'h3F, 7'h3F, 8'd10}, '{7'h6F, 7'h6F, 8'd10}};
    clear_events();
    foreach (tbl[j]) for (int c = 0; c < int'(tbl[j].n); c++) begin
      tick(tbl[j].t, tbl[j].o);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap step %0d cyc %0d: got %h want %h", j, c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (ev_val.size() != 3 || ev_val[1] != 0 || ev_fl[1] != 3'b100 || ev_val[2] != 99 || ev_fl[2] != 3'b010) begin
      n_fail++;
      $display("FAIL wrap_events: got n=%0d want 99, 0/up, 99/down", ev_val.size());
    end
  endtask

  task automatic test_glitch();
    stim_t tbl[$] = '{'{7'h3F, 7'h6D, 8'd10}, '{7'h3F, 7'h7F, 8'd3}, '{7'h3F, 7'h6D, 8'd10}};
    do_reset();
    clear_events();
    foreach (tbl[j]) for (int c = 0; c < int'(tbl[j].n); c++) begin
      tick(tbl[j].t, tbl[j].o);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch step %0d cyc %0d: got %h want %h", j, c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (ev_val.size() != 1 || n_ce != 0 || value !== 7'd5 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_events: got n=%0d ce=%0d v=%0d err=%0d want n=1 ce=0 v=5 err=0",
               ev_val.size(), n_ce, value, err_count);
    end
  endtask

  task automatic test_code_err();
    stim_t tbl[$] = '{'{7'h3F, 7'h00, 8'd10}, '{7'h3F, 7'h07, 8'd10}};
    clear_events();
    foreach (tbl[j]) for (int c = 0; c < int'(tbl[j].n); c++) begin
      tick(tbl[j].t, tbl[j].o);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL code_err step %0d cyc %0d: got %h want %h", j, c, obs_vec(), exp_vec());
      end
      if (j == 0 && c == int'(tbl[j].n) - 1) begin
        n_tests++;
        if (n_ce != 1 || value !== 7'd5 || err_count !== 8'd1) begin
          n_fail++;
          $display("FAIL code_err_pulse: got ce=%0d v=%0d err=%0d want ce=1 v=5 err=1", n_ce, value, err_count);
        end
      end
    end
    n_tests++;
    if (ev_val.size() != 1 || ev_val[0] != 7 || ev_fl[0] != 3'b001 || err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL step_err_events: got n=%0d err=%0d want 7/step_err err=2", ev_val.size(), err_count);
    end
  endtask

  task automatic test_reset_mid();
    stim_t tbl[$] = '{'{7'h66, 7'h5B, 8'd10}};
    foreach (tbl[j]) for (int c = 0; c < int'(tbl[j].n); c++) begin
      tick(tbl[j].t, tbl[j].o);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs_vec() !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want %h", obs_vec(), 21'h0);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_events();
    for (int c = 0; c < 10; c++) begin
      tick(7'h66, 7'h4F);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_post cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (ev_val.size() != 1 || ev_val[0] != 43 || ev_fl[0] != 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_first: got n=%0d want 43 with no step flag", ev_val.size());
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    for (int k = 0; k < 270; k++) begin
      for (int c = 0; c < 5; c++) begin
        if (k % 2 == 0) tick(7'h3F, 7'h00);
        else            tick(7'h00, 7'h3F);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL err_saturate k %0d cyc %0d: got %h want %h", k, c, obs_vec(), exp_vec());
        end
      end
    end
    n_tests++;
    if (err_count !== 8'hFF || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL err_saturate_final: got err=%0d lk=%b want err=255 lk=0", err_count, locked);
    end
  endtask

  task automatic test_random();
    int cur, hold, nxt;
    logic [6:0] t, o;
    do_reset();
    cur = 50;
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: nxt = (cur + 1) % 100;
        3, 4:    nxt = (cur + 99) % 100;
        5:       nxt = $urandom_range(0, 99);
        default: nxt = ($urandom_range(0, 1) == 0) ? 99 : 0;
      endcase
      t = CODES[nxt / 10];
      o = CODES[nxt % 10];
      if ($urandom_range(0, 7) == 0) o = 7'($urandom_range(0, 127));
      cur = nxt;
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        tick(t, o);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random k %0d cyc %0d: got %h want %h", k, c, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_value();
    test_up_down();
    test_wrap();
    test_glitch();
    test_code_err();
    test_reset_mid();
    test_err_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
